// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tlb_op_ctrl
// Description : Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB requests into
//               one-cycle TLB control pulses and reports completion status.
//               Optional macro TLBFILL_LFSR_EN selects an LFSR fill index
//               instead of the default wrapping counter.
// Revision    : 1.0 - initial release
// =============================================================================
module tlb_op_ctrl #(
    parameter int TLBNUM = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [4:0]  op_invop,
    input  logic [9:0]  op_asid,
    input  logic [18:0] op_vpn,
    input  logic [31:0] csr_tlbehi,
    output logic        tlbfill_en,
    output logic        tlbwr_en,
    output logic [4:0]  rand_index,
    output logic        invtlb_en,
    output logic [4:0]  invtlb_op,
    output logic [9:0]  invtlb_asid,
    output logic [18:0] invtlb_vpn,
    output logic        srch_req,
    output logic [31:0] srch_vaddr,
    input  logic        srch_found,
    input  logic [4:0]  srch_index,
    output logic        srch_we,
    output logic        srch_hit,
    output logic [4:0]  srch_idx,
    output logic        tlbrd_we,
    output logic        op_done,
    output logic        refetch,
    output logic        op_ill
);

    localparam logic [2:0] c_OP_TLBSRCH = 3'd0;
    localparam logic [2:0] c_OP_TLBRD   = 3'd1;
    localparam logic [2:0] c_OP_TLBWR   = 3'd2;
    localparam logic [2:0] c_OP_TLBFILL = 3'd3;
    localparam logic [2:0] c_OP_INVTLB  = 3'd4;
    localparam logic [4:0] c_INVOP_MAX  = 5'd6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRCH_REQ  = 3'd1,
        SRCH_WAIT = 3'd2,
        EXEC      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_code;
    logic [4:0]  r_invop;
    logic [9:0]  r_asid;
    logic [18:0] r_vpn;
    logic [4:0]  r_rand;
    logic        w_accept;
    logic        w_ill;
    logic        w_unused_ok;

    // The search address is page-aligned, so the low TLBEHI bits are dropped.
    assign w_unused_ok = &{1'b0, csr_tlbehi[12:0]};

    assign w_accept   = op_valid && (r_state == IDLE);
    assign w_ill      = (r_code > c_OP_INVTLB) ||
                        ((r_code == c_OP_INVTLB) && (r_invop > c_INVOP_MAX));
    assign rand_index = r_rand;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_code  <= 3'd0;
            r_invop <= 5'd0;
            r_asid  <= 10'd0;
            r_vpn   <= 19'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_code  <= op_code;
                r_invop <= op_invop;
                r_asid  <= op_asid;
                r_vpn   <= op_vpn;
            end
        end
    end

`ifdef TLBFILL_LFSR_EN
    // x^5 + x^3 + 1 is primitive: 31-state cycle that never reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rand <= 5'b00001;
        end else begin
            r_rand <= {r_rand[3:0], r_rand[4] ^ r_rand[2]};
        end
    end
`else
    localparam logic [4:0] c_RAND_LAST = 5'(TLBNUM - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rand <= 5'd0;
        end else if (r_rand == c_RAND_LAST) begin
            r_rand <= 5'd0;
        end else begin
            r_rand <= r_rand + 5'd1;
        end
    end
`endif

    always_comb begin
        w_next      = r_state;
        op_ready    = 1'b0;
        tlbfill_en  = 1'b0;
        tlbwr_en    = 1'b0;
        invtlb_en   = 1'b0;
        invtlb_op   = 5'd0;
        invtlb_asid = 10'd0;
        invtlb_vpn  = 19'd0;
        srch_req    = 1'b0;
        srch_vaddr  = 32'd0;
        srch_we     = 1'b0;
        srch_hit    = 1'b0;
        srch_idx    = 5'd0;
        tlbrd_we    = 1'b0;
        op_done     = 1'b0;
        refetch     = 1'b0;
        op_ill      = 1'b0;
        case (r_state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next = (op_code == c_OP_TLBSRCH) ? SRCH_REQ : EXEC;
                end
            end
            SRCH_REQ: begin
                srch_req   = 1'b1;
                srch_vaddr = {csr_tlbehi[31:13], 13'b0};
                w_next     = SRCH_WAIT;
            end
            SRCH_WAIT: begin
                srch_we  = 1'b1;
                srch_hit = srch_found;
                srch_idx = srch_found ? srch_index : 5'd0;
                w_next   = DONE;
            end
            EXEC: begin
                case (r_code)
                    c_OP_TLBRD:   tlbrd_we   = 1'b1;
                    c_OP_TLBWR:   tlbwr_en   = 1'b1;
                    c_OP_TLBFILL: tlbfill_en = 1'b1;
                    c_OP_INVTLB: begin
                        if (!w_ill) begin
                            invtlb_en   = 1'b1;
                            invtlb_op   = r_invop;
                            invtlb_asid = r_asid;
                            invtlb_vpn  = r_vpn;
                        end
                    end
                    default: ;
                endcase
                w_next = DONE;
            end
            DONE: begin
                op_done = 1'b1;
                refetch = (r_code == c_OP_TLBWR) || (r_code == c_OP_TLBFILL) ||
                          (r_code == c_OP_INVTLB);
                op_ill  = w_ill;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_tlb_op_ctrl
// Description : Directed and randomized self-checking bench for tlb_op_ctrl.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [4:0]  op_invop;
    logic [9:0]  op_asid;
    logic [18:0] op_vpn;
    logic [31:0] csr_tlbehi;
    logic        tlbfill_en, tlbwr_en, invtlb_en;
    logic [4:0]  rand_index, invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_vpn;
    logic        srch_req, srch_found, srch_we, srch_hit;
    logic [31:0] srch_vaddr;
    logic [4:0]  srch_index, srch_idx;
    logic        tlbrd_we, op_done, refetch, op_ill;

    int n_cmp = 0;
    int n_err = 0;
    int rcnt  = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_invop(op_invop), .op_asid(op_asid), .op_vpn(op_vpn),
        .csr_tlbehi(csr_tlbehi),
        .tlbfill_en(tlbfill_en), .tlbwr_en(tlbwr_en), .rand_index(rand_index),
        .invtlb_en(invtlb_en), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
        .invtlb_vpn(invtlb_vpn),
        .srch_req(srch_req), .srch_vaddr(srch_vaddr),
        .srch_found(srch_found), .srch_index(srch_index),
        .srch_we(srch_we), .srch_hit(srch_hit), .srch_idx(srch_idx),
        .tlbrd_we(tlbrd_we), .op_done(op_done), .refetch(refetch), .op_ill(op_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each cycle starts at a falling edge; rcnt = cycles since the last reset edge.
    task automatic next_cycle();
        @(negedge clk);
        if (reset) rcnt = 0;
        else       rcnt++;
    endtask

    task automatic chk_rand(input string tag);
`ifdef TLBFILL_LFSR_EN
        chk(tag, {31'd0, rand_index == 5'd0}, 32'd0);
`else
        chk(tag, rand_index, rcnt % TLBNUM);
`endif
    endtask

    task automatic scramble();
        op_code    = 3'($urandom);
        op_invop   = 5'($urandom);
        op_asid    = 10'($urandom);
        op_vpn     = 19'($urandom);
        srch_found = 1'($urandom);
        srch_index = 5'($urandom);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, ".ready"},   op_ready, 1);
        chk({tag, ".fill"},    tlbfill_en, 0);
        chk({tag, ".wr"},      tlbwr_en, 0);
        chk({tag, ".inv"},     {invtlb_en, invtlb_op, invtlb_asid, invtlb_vpn}, 0);
        chk({tag, ".sreq"},    srch_req, 0);
        chk({tag, ".svaddr"},  srch_vaddr, 0);
        chk({tag, ".swb"},     {srch_we, srch_hit, srch_idx}, 0);
        chk({tag, ".rd"},      tlbrd_we, 0);
        chk({tag, ".status"},  {op_done, refetch, op_ill}, 0);
        chk_rand({tag, ".rand"});
    endtask

    // Presents one op in an idle cycle, then checks every cycle up to op_done
    // against the per-op timeline derived from the op's kind and operands.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [4:0] invop,
                          input logic [9:0] asid, input logic [18:0] vpn,
                          input logic [31:0] ehi, input logic found, input logic [4:0] sidx);
        int   lat;
        logic ill;
        logic e_req, e_we, e_hit, e_rd, e_wr, e_fill, e_inv, e_done, e_ref, e_ill;
        logic [4:0]  e_idx, e_iop;
        logic [9:0]  e_asid;
        logic [18:0] e_vpn;
        logic [31:0] e_vaddr;
        lat = (code == 3'd0) ? 3 : 2;
        ill = (code > 3'd4) || (code == 3'd4 && invop > 5'd6);
        next_cycle();
        scramble();
        op_valid = 1'b1; op_code = code; op_invop = invop; op_asid = asid;
        op_vpn = vpn; csr_tlbehi = ehi;
        #1 chk({tag, ".accept"}, op_ready, 1);
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            scramble();
            op_valid = 1'($urandom);
            if (code == 3'd0 && k == 2) begin
                srch_found = found;
                srch_index = sidx;
            end
            #1;
            e_req   = (code == 3'd0) && (k == 1);
            e_vaddr = e_req ? {ehi[31:13], 13'd0} : 32'd0;
            e_we    = (code == 3'd0) && (k == 2);
            e_hit   = e_we && found;
            e_idx   = e_hit ? sidx : 5'd0;
            e_rd    = (code == 3'd1) && (k == 1);
            e_wr    = (code == 3'd2) && (k == 1);
            e_fill  = (code == 3'd3) && (k == 1);
            e_inv   = (code == 3'd4) && !ill && (k == 1);
            e_iop   = e_inv ? invop : 5'd0;
            e_asid  = e_inv ? asid : 10'd0;
            e_vpn   = e_inv ? vpn : 19'd0;
            e_done  = (k == lat);
            e_ref   = e_done && (code == 3'd2 || code == 3'd3 || code == 3'd4);
            e_ill   = e_done && ill;
            chk({tag, ".ready"},  op_ready, 0);
            chk({tag, ".sreq"},   srch_req, e_req);
            chk({tag, ".svaddr"}, srch_vaddr, e_vaddr);
            chk({tag, ".swe"},    srch_we, e_we);
            chk({tag, ".shit"},   srch_hit, e_hit);
            chk({tag, ".sidx"},   srch_idx, e_idx);
            chk({tag, ".rd"},     tlbrd_we, e_rd);
            chk({tag, ".wr"},     tlbwr_en, e_wr);
            chk({tag, ".fill"},   tlbfill_en, e_fill);
            chk({tag, ".inv"},    invtlb_en, e_inv);
            chk({tag, ".invf"},   {invtlb_op, invtlb_asid, invtlb_vpn}, {e_iop, e_asid, e_vpn});
            chk({tag, ".done"},   op_done, e_done);
            chk({tag, ".refetch"}, refetch, e_ref);
            chk({tag, ".ill"},    op_ill, e_ill);
            chk_rand({tag, ".rand"});
        end
    endtask

    logic [4:0] rvals [62];

    initial begin
        int dup;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_invop = 5'd0;
        op_asid = 10'd0; op_vpn = 19'd0; csr_tlbehi = 32'd0;
        srch_found = 1'b0; srch_index = 5'd0;
        next_cycle();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1 idle_checks("reset");
`ifdef TLBFILL_LFSR_EN
        chk("reset.seed", rand_index, 1);
`else
        chk("reset.rand0", rand_index, 0);
`endif

        // Free-running fill index from reset.
        rvals[0] = rand_index;
        for (int i = 1; i < 62; i++) begin
            next_cycle();
            scramble();
            op_valid = 1'b0;
            #1 rvals[i] = rand_index;
            chk("idle.ready", op_ready, 1);
        end
`ifdef TLBFILL_LFSR_EN
        for (int i = 0; i < 31; i++) begin
            dup = 0;
            for (int j = 0; j < i; j++) if (rvals[j] == rvals[i]) dup++;
            chk("lfsr.nonzero", {31'd0, rvals[i] == 5'd0}, 0);
            chk("lfsr.distinct", dup, 0);
        end
        for (int i = 31; i < 62; i++) chk("lfsr.period", rvals[i], rvals[i-31]);
`else
        for (int i = 0; i < 62; i++) chk("cnt.seq", rvals[i], i % TLBNUM);
`endif

        run_op("srch_hit",  3'd0, 5'd0, 10'd0, 19'd0, 32'h1234_5000, 1'b1, 5'd7);
        run_op("srch_miss", 3'd0, 5'd0, 10'd0, 19'd0, 32'hFFFF_FFFF, 1'b0, 5'h1F);
        run_op("inv_ok",    3'd4, 5'd5, 10'h3, 19'h1ABCD, 32'd0, 1'b0, 5'd0);
        run_op("inv_bad",   3'd4, 5'd7, 10'h3, 19'h1ABCD, 32'd0, 1'b0, 5'd0);
        run_op("tlbrd",     3'd1, 5'd0, 10'd0, 19'd0, 32'd0, 1'b0, 5'd0);
        run_op("tlbwr",     3'd2, 5'd0, 10'd0, 19'd0, 32'd0, 1'b0, 5'd0);
        run_op("tlbfill",   3'd3, 5'd0, 10'd0, 19'd0, 32'd0, 1'b0, 5'd0);
        run_op("illegal",   3'd6, 5'd0, 10'd0, 19'd0, 32'd0, 1'b0, 5'd0);

        // Back-to-back TLBWR then TLBRD with op_valid held high.
        next_cycle(); op_valid = 1'b1; op_code = 3'd2;
        #1 chk("b2b.acc1", op_ready, 1);
        next_cycle(); op_code = 3'd1;
        #1 chk("b2b.wr", tlbwr_en, 1);
        chk("b2b.busy1", op_ready, 0);
        chk("b2b.rd_early", tlbrd_we, 0);
        next_cycle();
        #1 chk("b2b.done1", {op_done, refetch, op_ready}, 3'b110);
        next_cycle();
        #1 chk("b2b.acc2", op_ready, 1);
        next_cycle(); op_valid = 1'b0;
        #1 chk("b2b.rd", {tlbrd_we, tlbwr_en}, 2'b10);
        next_cycle();
        #1 chk("b2b.done2", {op_done, refetch}, 2'b10);
        next_cycle();
        #1 idle_checks("b2b.idle");

        // Reset while a TLBFILL is in EXEC.
        next_cycle(); op_valid = 1'b1; op_code = 3'd3;
        #1 chk("rst.acc", op_ready, 1);
        next_cycle(); op_valid = 1'b0; reset = 1'b1;
        #1 chk("rst.fill_pre", tlbfill_en, 1);
        next_cycle(); reset = 1'b0;
        #1 idle_checks("rst.after");
        next_cycle();
        #1 idle_checks("rst.after2");

        for (int n = 0; n < 60; n++) begin
            logic [2:0] code;
            if ($urandom_range(0, 2) == 0) begin
                next_cycle();
                scramble();
                op_valid = 1'b0;
                #1 idle_checks("rnd.idle");
            end
            code = ($urandom_range(0, 9) > 7) ? 3'd4 : 3'($urandom_range(0, 7));
            run_op("rnd", code, 5'($urandom_range(0, 7)), 10'($urandom), 19'($urandom),
                   $urandom, 1'($urandom), 5'($urandom));
        end

        next_cycle();
        op_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
